// File: rtl/fetch_pc_sel_pkg.sv
// Shared Y86 fetch definitions: opcode constants, fetch FSM encoding, address type.
// Latency: none (types/constants only). Backpressure: not applicable.
package fetch_pc_sel_pkg;

    localparam logic [3:0] Y86_HALT = 4'h0;
    localparam logic [3:0] Y86_NOP  = 4'h1;
    localparam logic [3:0] Y86_JXX  = 4'h7;
    localparam logic [3:0] Y86_CALL = 4'h8;
    localparam logic [3:0] Y86_RET  = 4'h9;

    typedef logic [63:0] addr_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        RET_WAIT = 2'd1,
        HALTED   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_pc_sel_if.sv
// Fetch-stage PC selection bus: fetched instruction, M/W feedback and fetch outputs.
// Latency: none (wiring only). Backpressure: F_stall carried from the pipeline control.
interface fetch_pc_sel_if;
    import fetch_pc_sel_pkg::*;

    logic [3:0]  f_icode;
    addr_t       f_valC;
    addr_t       f_valP;
    logic        F_stall;
    logic [3:0]  M_icode;
    logic        M_cnd;
    addr_t       M_valA;
    logic [3:0]  W_icode;
    addr_t       W_valM;
    addr_t       f_pc;
    addr_t       F_predPC;
    logic        f_valid;
    logic        redirect;
    logic [31:0] fetch_count;

    modport master (
        output f_icode, f_valC, f_valP, F_stall,
        output M_icode, M_cnd, M_valA, W_icode, W_valM,
        input  f_pc, F_predPC, f_valid, redirect, fetch_count
    );

    modport slave (
        input  f_icode, f_valC, f_valP, F_stall,
        input  M_icode, M_cnd, M_valA, W_icode, W_valM,
        output f_pc, F_predPC, f_valid, redirect, fetch_count
    );

endinterface

// File: rtl/fetch_pc_sel_pc_predict.sv
// Next-PC predictor: jumps and calls predicted taken to valC, everything else falls through.
// Latency: combinational. Backpressure: none.
module fetch_pc_sel_pc_predict
    import fetch_pc_sel_pkg::*;
#(
    parameter logic [3:0] ICODE_JXX  = Y86_JXX,
    parameter logic [3:0] ICODE_CALL = Y86_CALL
) (
    input  logic [3:0] i_icode,
    input  addr_t      i_valC,
    input  addr_t      i_valP,
    output addr_t      o_pred_pc
);

    always_comb begin
        o_pred_pc = i_valP;
        if ((i_icode == ICODE_JXX) || (i_icode == ICODE_CALL)) begin
            o_pred_pc = i_valC;
        end
    end

endmodule

// File: rtl/fetch_pc_sel.sv
// Y86 fetch PC select: picks f_pc from mispredict/return/prediction, tracks RET and HALT bubbles.
// Latency: f_pc combinational, F_predPC one edge. Backpressure: F_stall holds unless redirected.
module fetch_pc_sel
    import fetch_pc_sel_pkg::*;
#(
    parameter logic [3:0] ICODE_HALT = Y86_HALT,
    parameter logic [3:0] ICODE_JXX  = Y86_JXX,
    parameter logic [3:0] ICODE_CALL = Y86_CALL,
    parameter logic [3:0] ICODE_RET  = Y86_RET
) (
    input  logic           clk,
    input  logic           reset,
    fetch_pc_sel_if.slave  bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    addr_t        r_pred_pc;
    addr_t        w_pred_nxt_pc;
    addr_t        w_f_pc;
    logic [31:0]  r_fetch_count;
    logic         w_mispredict;
    logic         w_ret_done;
    logic         w_redirect;
    logic         w_fetch_active;
    logic         w_advance;

    fetch_pc_sel_pc_predict #(
        .ICODE_JXX  (ICODE_JXX),
        .ICODE_CALL (ICODE_CALL)
    ) u_pc_predict (
        .i_icode   (bus.f_icode),
        .i_valC    (bus.f_valC),
        .i_valP    (bus.f_valP),
        .o_pred_pc (w_pred_nxt_pc)
    );

    always_comb begin
        w_mispredict   = (bus.M_icode == ICODE_JXX) && !bus.M_cnd;
        w_ret_done     = (bus.W_icode == ICODE_RET);
        w_redirect     = w_mispredict || w_ret_done;
        w_f_pc         = r_pred_pc;
        if (w_mispredict) begin
            w_f_pc = bus.M_valA;
        end else if (w_ret_done) begin
            w_f_pc = bus.W_valM;
        end
        // A mispredict squashes whatever bubble state we are in and fetches like RUN.
        w_fetch_active = w_mispredict || (r_state == RUN) ||
                         ((r_state == RET_WAIT) && w_ret_done);
        w_advance      = w_fetch_active && (!bus.F_stall || w_redirect);
        w_state_nxt    = r_state;
        if (w_advance) begin
            if (bus.f_icode == ICODE_RET) begin
                w_state_nxt = RET_WAIT;
            end else if (bus.f_icode == ICODE_HALT) begin
                w_state_nxt = HALTED;
            end else begin
                w_state_nxt = RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= RUN;
            r_pred_pc     <= '0;
            r_fetch_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_advance) begin
                r_pred_pc     <= w_pred_nxt_pc;
                r_fetch_count <= r_fetch_count + 32'd1;
            end
        end
    end

    assign bus.f_pc        = w_f_pc;
    assign bus.F_predPC    = r_pred_pc;
    assign bus.f_valid     = w_fetch_active;
    assign bus.redirect    = w_redirect;
    assign bus.fetch_count = r_fetch_count;

endmodule

// File: tb/tb_fetch_pc_sel.sv
// Directed bench for fetch_pc_sel: reset, prediction, mispredict, RET/HALT bubbles, stall, wrap.
module tb_fetch_pc_sel;
    import fetch_pc_sel_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fetch_pc_sel_if bus ();

    fetch_pc_sel dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.f_icode = 4'h1;
        bus.f_valC  = 64'h0;
        bus.f_valP  = 64'h0;
        bus.F_stall = 1'b0;
        bus.M_icode = 4'h1;
        bus.M_cnd   = 1'b0;
        bus.M_valA  = 64'h0;
        bus.W_icode = 4'h1;
        bus.W_valM  = 64'h0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.F_predPC !== 64'h0) begin failures++; $display("FAIL reset_predpc got=%h exp=%h", bus.F_predPC, 64'h0); end
        checks++; if (bus.fetch_count !== 32'h0) begin failures++; $display("FAIL reset_count got=%h exp=%h", bus.fetch_count, 32'h0); end
        checks++; if (bus.f_pc !== 64'h0) begin failures++; $display("FAIL reset_fpc got=%h exp=%h", bus.f_pc, 64'h0); end
        checks++; if (bus.f_valid !== 1'b1) begin failures++; $display("FAIL reset_valid got=%b exp=1", bus.f_valid); end
        checks++; if (bus.redirect !== 1'b0) begin failures++; $display("FAIL reset_redirect got=%b exp=0", bus.redirect); end
    endtask

    task automatic test_nop();
        do_reset();
        bus.f_icode = 4'h1;
        bus.f_valP  = 64'h2;
        step();
        checks++; if (bus.F_predPC !== 64'h2) begin failures++; $display("FAIL nop_predpc got=%h exp=%h", bus.F_predPC, 64'h2); end
        checks++; if (bus.f_pc !== 64'h2) begin failures++; $display("FAIL nop_fpc got=%h exp=%h", bus.f_pc, 64'h2); end
        step();
        step();
        checks++; if (bus.fetch_count !== 32'd3) begin failures++; $display("FAIL nop_count got=%0d exp=3", bus.fetch_count); end
        checks++; if (bus.redirect !== 1'b0) begin failures++; $display("FAIL nop_redirect got=%b exp=0", bus.redirect); end
    endtask

    task automatic test_branch();
        do_reset();
        bus.f_icode = 4'h7;
        bus.f_valC  = 64'h40;
        bus.f_valP  = 64'h9;
        step();
        checks++; if (bus.F_predPC !== 64'h40) begin failures++; $display("FAIL jxx_predpc got=%h exp=%h", bus.F_predPC, 64'h40); end
        bus.f_icode = 4'h1;
        bus.f_valP  = 64'h41;
        step();
        step();
        bus.M_icode = 4'h7;
        bus.M_cnd   = 1'b1;
        #1;
        checks++; if (bus.redirect !== 1'b0 || bus.f_pc !== 64'h41) begin failures++; $display("FAIL jxx_taken got=%b/%h exp=0/%h", bus.redirect, bus.f_pc, 64'h41); end
        bus.M_cnd   = 1'b0;
        bus.M_valA  = 64'h9;
        bus.f_valP  = 64'hA;
        #1;
        checks++; if (bus.f_pc !== 64'h9) begin failures++; $display("FAIL mispredict_fpc got=%h exp=%h", bus.f_pc, 64'h9); end
        checks++; if (bus.redirect !== 1'b1) begin failures++; $display("FAIL mispredict_redirect got=%b exp=1", bus.redirect); end
        step();
        bus.M_icode = 4'h1;
        #1;
        checks++; if (bus.F_predPC !== 64'hA) begin failures++; $display("FAIL mispredict_predpc got=%h exp=%h", bus.F_predPC, 64'hA); end
        checks++; if (bus.fetch_count !== 32'd4) begin failures++; $display("FAIL mispredict_count got=%0d exp=4", bus.fetch_count); end
    endtask

    task automatic test_ret();
        do_reset();
        bus.f_valP = 64'h20;
        step();
        bus.f_icode = 4'h9;
        bus.f_valP  = 64'h21;
        #1;
        checks++; if (bus.f_pc !== 64'h20 || bus.f_valid !== 1'b1) begin failures++; $display("FAIL ret_fetch got=%h/%b exp=%h/1", bus.f_pc, bus.f_valid, 64'h20); end
        step();
        bus.f_icode = 4'h1;
        bus.f_valP  = 64'h77;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL ret_bubble%0d got=%b exp=0", i, bus.f_valid); end
            step();
        end
        checks++; if (bus.F_predPC !== 64'h21 || bus.fetch_count !== 32'd2) begin failures++; $display("FAIL ret_hold got=%h/%0d exp=%h/2", bus.F_predPC, bus.fetch_count, 64'h21); end
        bus.W_icode = 4'h9;
        bus.W_valM  = 64'h15;
        bus.f_valP  = 64'h16;
        #1;
        checks++; if (bus.f_pc !== 64'h15 || bus.f_valid !== 1'b1) begin failures++; $display("FAIL ret_resume got=%h/%b exp=%h/1", bus.f_pc, bus.f_valid, 64'h15); end
        step();
        bus.W_icode = 4'h1;
        #1;
        checks++; if (bus.F_predPC !== 64'h16 || bus.f_valid !== 1'b1) begin failures++; $display("FAIL ret_run got=%h/%b exp=%h/1", bus.F_predPC, bus.f_valid, 64'h16); end
        checks++; if (bus.fetch_count !== 32'd3) begin failures++; $display("FAIL ret_count got=%0d exp=3", bus.fetch_count); end
    endtask

    task automatic test_halt();
        do_reset();
        bus.f_icode = 4'h0;
        bus.f_valP  = 64'h1;
        step();
        bus.f_icode = 4'h1;
        bus.f_valP  = 64'h5;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL halt_bubble%0d got=%b exp=0", i, bus.f_valid); end
            step();
        end
        checks++; if (bus.fetch_count !== 32'd1 || bus.F_predPC !== 64'h1) begin failures++; $display("FAIL halt_frozen got=%0d/%h exp=1/%h", bus.fetch_count, bus.F_predPC, 64'h1); end
        bus.W_icode = 4'h9;
        bus.W_valM  = 64'h88;
        step();
        bus.W_icode = 4'h1;
        #1;
        checks++; if (bus.f_valid !== 1'b0 || bus.fetch_count !== 32'd1) begin failures++; $display("FAIL halt_ret_ignored got=%b/%0d exp=0/1", bus.f_valid, bus.fetch_count); end
        bus.M_icode = 4'h7;
        bus.M_cnd   = 1'b0;
        bus.M_valA  = 64'h30;
        bus.f_valP  = 64'h31;
        #1;
        checks++; if (bus.f_pc !== 64'h30 || bus.f_valid !== 1'b1) begin failures++; $display("FAIL halt_exit got=%h/%b exp=%h/1", bus.f_pc, bus.f_valid, 64'h30); end
        step();
        bus.M_icode = 4'h1;
        #1;
        checks++; if (bus.F_predPC !== 64'h31 || bus.f_valid !== 1'b1 || bus.fetch_count !== 32'd2) begin failures++; $display("FAIL halt_run got=%h/%b/%0d exp=%h/1/2", bus.F_predPC, bus.f_valid, bus.fetch_count, 64'h31); end
    endtask

    task automatic test_stall();
        do_reset();
        bus.f_valP = 64'h10;
        step();
        bus.F_stall = 1'b1;
        bus.f_valP  = 64'h99;
        step();
        step();
        checks++; if (bus.F_predPC !== 64'h10) begin failures++; $display("FAIL stall_predpc got=%h exp=%h", bus.F_predPC, 64'h10); end
        checks++; if (bus.fetch_count !== 32'd1) begin failures++; $display("FAIL stall_count got=%0d exp=1", bus.fetch_count); end
        bus.M_icode = 4'h7;
        bus.M_cnd   = 1'b0;
        bus.M_valA  = 64'h50;
        bus.f_icode = 4'h7;
        bus.f_valC  = 64'h60;
        bus.f_valP  = 64'h5A;
        step();
        bus.M_icode = 4'h1;
        #1;
        checks++; if (bus.F_predPC !== 64'h60) begin failures++; $display("FAIL stall_redirect_predpc got=%h exp=%h", bus.F_predPC, 64'h60); end
        checks++; if (bus.fetch_count !== 32'd2) begin failures++; $display("FAIL stall_redirect_count got=%0d exp=2", bus.fetch_count); end
        bus.F_stall = 1'b0;
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        force dut.r_fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_fetch_count;
        #1;
        checks++; if (bus.fetch_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preload got=%h exp=%h", bus.fetch_count, 32'hFFFF_FFFF); end
        step();
        checks++; if (bus.fetch_count !== 32'h0) begin failures++; $display("FAIL wrap_count got=%h exp=%h", bus.fetch_count, 32'h0); end
        do_reset();
        bus.f_icode = 4'h9;
        bus.f_valP  = 64'h3;
        step();
        bus.f_icode = 4'h1;
        #1;
        checks++; if (bus.f_valid !== 1'b0) begin failures++; $display("FAIL retwait_entry got=%b exp=0", bus.f_valid); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (bus.f_pc !== 64'h0 || bus.f_valid !== 1'b1 || bus.fetch_count !== 32'h0) begin failures++; $display("FAIL retwait_reset got=%h/%b/%0d exp=0/1/0", bus.f_pc, bus.f_valid, bus.fetch_count); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        set_idle();
        test_reset();
        test_nop();
        test_branch();
        test_ret();
        test_halt();
        test_stall();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_sel.md
FETCH_PC_SEL -- requirements
Module: fetch_pc_sel

Interface
REQ-001 SHALL have parameter ICODE_HALT, default 4'h0, halt opcode.
REQ-002 SHALL have parameter ICODE_JXX / ICODE_CALL / ICODE_RET, defaults 4'h7 / 4'h8 / 4'h9, branch, call and return opcodes.
REQ-003 SHALL have port clk, input, 1, single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have ports f_icode in 4, f_valC in 64, f_valP in 64: opcode, constant word and fall-through address of the instruction fetched at f_pc.
REQ-006 SHALL have port F_stall, input, 1: hold the fetch register.
REQ-007 SHALL have ports M_icode in 4, M_cnd in 1, M_valA in 64: memory-stage opcode, branch outcome and fall-through address.
REQ-008 SHALL have ports W_icode in 4, W_valM in 64: write-back-stage opcode and loaded return address.
REQ-009 SHALL have ports f_pc out 64, F_predPC out 64, f_valid out 1, redirect out 1, fetch_count out 32.

Function
REQ-010 SHALL compute f_pc combinationally with priority: M_icode==JXX && !M_cnd -> M_valA; else W_icode==RET -> W_valM; else F_predPC.
REQ-011 SHALL drive redirect=1 whenever f_pc comes from the first or second source in REQ-010.
REQ-012 SHALL predict next PC as f_valC for f_icode JXX or CALL; otherwise f_valP. Predict-taken applies to all JXX.
REQ-013 SHALL implement FSM states RUN, RET_WAIT, HALTED in a registered state variable.
REQ-014 In RUN, f_valid=1, and on an unstalled edge F_predPC loads the predicted PC.
REQ-015 In RUN, if f_icode==RET with F_stall=0 and no redirect, the FSM SHALL enter RET_WAIT on the next edge.
REQ-016 In RUN, if f_icode==HALT with F_stall=0 and no redirect, the FSM SHALL enter HALTED on the next edge.
REQ-017 In RET_WAIT, f_valid=0 (bubble) and F_predPC SHALL be held until W_icode==RET.
REQ-018 When W_icode==RET in RET_WAIT, f_valid=1 and f_pc=W_valM. The FSM SHALL take REQ-014 and REQ-015 as in RUN on that edge, so a RET fetched at W_valM re-enters RET_WAIT.
REQ-019 In HALTED, f_valid=0 and F_predPC is held. Only a mispredict or reset SHALL leave HALTED.
REQ-020 On a mispredict in any state, the FSM SHALL act as RUN for that cycle: f_valid=1, fetch at M_valA, next state from the instruction at M_valA. This squashes a wrong-path RET or HALT.
REQ-021 Redirect SHALL override F_stall: a redirected cycle always updates F_predPC and state.
REQ-022 With F_stall=1 and no redirect, F_predPC, state and fetch_count SHALL hold.
REQ-023 fetch_count SHALL increment by 1 on each edge with f_valid=1 and (F_stall=0 or redirect=1), wrapping 0xFFFF_FFFF -> 0.
REQ-024 Address arithmetic is done outside this block. All 64-bit values pass unmodified with no overflow handling.

Reset
REQ-025 On a rising clk edge with reset=1: F_predPC=0, state=RUN, fetch_count=0. Reset overrides stall and redirect.
REQ-026 After reset with no redirect inputs: f_pc=0, f_valid=1, redirect=0.
REQ-027 Reset asserted mid RET_WAIT or HALTED SHALL return the block to RUN at PC 0 on the next edge.

Structure
REQ-028 Opcode constants and FSM state encodings SHALL live in the shared Y86 definitions package/include used by the pipeline stages.
REQ-029 The block is a single module with one natural sub-module, pc_predict: the combinational REQ-012 next-PC predictor.
REQ-030 The module SHALL contain no delays; all timing is clocked.

Verification
REQ-031 Reset then f_icode=1 (nop), f_valP=0x2 for 3 cycles -> F_predPC 0x2 after first edge, fetch_count=3, redirect=0.
REQ-032 f_icode=7, f_valC=0x40, f_valP=0x9 -> F_predPC=0x40. Two cycles later M_icode=7, M_cnd=0, M_valA=0x9 -> f_pc=0x9, redirect=1.
REQ-033 f_icode=9 at PC 0x20 -> f_valid=0 for 3 cycles. Then W_icode=9, W_valM=0x15 -> f_pc=0x15, f_valid=1, state RUN.
REQ-034 f_icode=0 (halt) -> f_valid=0 indefinitely, fetch_count frozen. Mispredict with M_valA=0x30 -> f_pc=0x30, f_valid=1.
REQ-035 F_stall=1 for 2 cycles with F_predPC=0x10 -> F_predPC stays 0x10. F_stall=1 with a simultaneous mispredict (M_valA=0x50) -> F_predPC updates from the instruction at 0x50.
REQ-036 Preload fetch_count=0xFFFF_FFFF, one valid fetch -> 0x0. Reset asserted in RET_WAIT -> f_pc=0, f_valid=1 next cycle.
